// File: rtl/apb_rf_pkg.sv
// Shared definitions for the APB register-file bridge.
//   state_e      : bridge FSM states
//   CNT_W        : width of the wait/latency down-counter
//   max_u()      : larger of two unsigned values (read completion delay)
//   CTRL..BAUDIV : indices of the UART registers behind the bridge
package apb_rf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WAIT,
        DONE
    } state_e;

    localparam int unsigned CNT_W = 4;

    localparam int unsigned CTRL    = 0;
    localparam int unsigned STATUS  = 1;
    localparam int unsigned TX_DATA = 2;
    localparam int unsigned RX_DATA = 3;
    localparam int unsigned BAUDIV  = 4;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/apb_rf_decode.sv
// Combinational APB address decoder.
//   paddr  : APB byte address
//   rf_idx : word index into the register file (paddr[RF_AW+1:2])
//   err    : misaligned address or word index beyond the implemented
//            registers (the full upper address is compared, so no aliasing)
module apb_rf_decode
    import apb_rf_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned NUM_REGS = 5,
    parameter int unsigned RF_AW    = 3
) (
    input  logic [ADDR_W-1:0] paddr,
    output logic [RF_AW-1:0]  rf_idx,
    output logic              err
);

    localparam logic [ADDR_W-3:0] LIMIT = (ADDR_W-2)'(NUM_REGS);

    always_comb begin
        rf_idx = paddr[RF_AW+1:2];
        err    = (paddr[1:0] != 2'b00) || (paddr[ADDR_W-1:2] >= LIMIT);
    end

endmodule

// File: rtl/apb_rf_bridge.sv
// APB4 slave bridge in front of a NUM_REGS-word register file.
//   PCLK, PRESETn                 : clock, asynchronous active-low reset
//   PSEL/PENABLE/PWRITE/PADDR/
//   PWDATA/PSTRB                  : APB request
//   PRDATA/PREADY/PSLVERR         : APB response (registered, PREADY is a
//                                   one-cycle pulse in the last access cycle)
//   rf_wr_en/rf_rd_en             : one-cycle register-file strobes
//   rf_addr/rf_wdata/rf_wstrb     : register-file index, data, byte enables
//   rf_rdata                      : register-file read data, RD_LAT cycles
//                                   after the rf_rd_en cycle
module apb_rf_bridge
    import apb_rf_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned NUM_REGS    = 5,
    parameter int unsigned RF_AW       = 3,
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [ADDR_W-1:0]   PADDR,
    input  logic [DATA_W-1:0]   PWDATA,
    input  logic [DATA_W/8-1:0] PSTRB,
    output logic [DATA_W-1:0]   PRDATA,
    output logic                PREADY,
    output logic                PSLVERR,
    output logic                rf_wr_en,
    output logic                rf_rd_en,
    output logic [RF_AW-1:0]    rf_addr,
    output logic [DATA_W-1:0]   rf_wdata,
    output logic [DATA_W/8-1:0] rf_wstrb,
    input  logic [DATA_W-1:0]   rf_rdata
);

    localparam int unsigned STRB_W = DATA_W / 8;

    // Extra WAIT cycles: good reads must also cover the register-file latency.
    localparam logic [CNT_W-1:0] N_PLAIN = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] N_READ  = CNT_W'(max_u(WAIT_STATES, RD_LAT));

    logic [RF_AW-1:0] dec_idx;
    logic             dec_err;

    apb_rf_decode #(
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS),
        .RF_AW   (RF_AW)
    ) u_decode (
        .paddr (PADDR),
        .rf_idx(dec_idx),
        .err   (dec_err)
    );

    state_e              state_q,    state_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic                write_q,    write_d;
    logic                err_q,      err_d;
    logic [STRB_W-1:0]   strb_q,     strb_d;
    logic [RF_AW-1:0]    rf_addr_q,  rf_addr_d;
    logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
    logic [STRB_W-1:0]   rf_wstrb_q, rf_wstrb_d;
    logic                rf_wr_en_q, rf_wr_en_d;
    logic                rf_rd_en_q, rf_rd_en_d;
    logic [DATA_W-1:0]   prdata_q,   prdata_d;
    logic                pready_q,   pready_d;
    logic                pslverr_q,  pslverr_d;
    logic                capture;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        err_d      = err_q;
        strb_d     = strb_q;
        rf_addr_d  = rf_addr_q;
        rf_wdata_d = rf_wdata_q;
        rf_wstrb_d = rf_wstrb_q;
        rf_wr_en_d = 1'b0;
        rf_rd_en_d = 1'b0;
        prdata_d   = prdata_q;
        pready_d   = 1'b0;
        pslverr_d  = 1'b0;

        // A setup phase seen in IDLE or SETUP (re)captures the request.
        capture = ((state_q == IDLE) || (state_q == SETUP)) && PSEL && !PENABLE;
        if (capture) begin
            rf_addr_d  = dec_idx;
            rf_wdata_d = PWDATA;
            strb_d     = PSTRB;
            write_d    = PWRITE;
            err_d      = dec_err;
        end

        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (PENABLE) begin
                    if (!err_q) begin
                        if (write_q) begin
                            if (strb_q != '0) begin
                                rf_wr_en_d = 1'b1;
                                rf_wstrb_d = strb_q;
                            end
                        end else begin
                            rf_rd_en_d = 1'b1;
                            rf_wstrb_d = '0;
                        end
                    end
                    cnt_d   = (write_q || err_q) ? N_PLAIN : N_READ;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    pready_d  = 1'b1;
                    pslverr_d = err_q;
                    if (!write_q) begin
                        prdata_d = err_q ? '0 : rf_rdata;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            strb_q     <= '0;
            rf_addr_q  <= '0;
            rf_wdata_q <= '0;
            rf_wstrb_q <= '0;
            rf_wr_en_q <= 1'b0;
            rf_rd_en_q <= 1'b0;
            prdata_q   <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            write_q    <= write_d;
            err_q      <= err_d;
            strb_q     <= strb_d;
            rf_addr_q  <= rf_addr_d;
            rf_wdata_q <= rf_wdata_d;
            rf_wstrb_q <= rf_wstrb_d;
            rf_wr_en_q <= rf_wr_en_d;
            rf_rd_en_q <= rf_rd_en_d;
            prdata_q   <= prdata_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
        end
    end

    assign PRDATA   = prdata_q;
    assign PREADY   = pready_q;
    assign PSLVERR  = pslverr_q;
    assign rf_wr_en = rf_wr_en_q;
    assign rf_rd_en = rf_rd_en_q;
    assign rf_addr  = rf_addr_q;
    assign rf_wdata = rf_wdata_q;
    assign rf_wstrb = rf_wstrb_q;

endmodule

// File: tb/tb_apb_rf_bridge.sv
// Bench for apb_rf_bridge: two instances (default timing, and
// WAIT_STATES=3 / RD_LAT=5), each with its own register-file model.
module tb_apb_rf_bridge;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = DW / 8;

    logic pclk;
    logic presetn;

    logic          psel     [2];
    logic          penable  [2];
    logic          pwrite   [2];
    logic [AW-1:0] paddr    [2];
    logic [DW-1:0] pwdata   [2];
    logic [SW-1:0] pstrb    [2];
    logic [DW-1:0] prdata   [2];
    logic          pready   [2];
    logic          pslverr  [2];
    logic          wr_en    [2];
    logic          rd_en    [2];
    logic [2:0]    rf_addr  [2];
    logic [DW-1:0] rf_wdata [2];
    logic [SW-1:0] rf_wstrb [2];
    logic [DW-1:0] rf_rdata [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        apb_rf_bridge #(
            .DATA_W     (DW),
            .ADDR_W     (AW),
            .NUM_REGS   (5),
            .RF_AW      (3),
            .RD_LAT     ((g == 0) ? 1 : 5),
            .WAIT_STATES((g == 0) ? 0 : 3)
        ) u_dut (
            .PCLK    (pclk),
            .PRESETn (presetn),
            .PSEL    (psel[g]),
            .PENABLE (penable[g]),
            .PWRITE  (pwrite[g]),
            .PADDR   (paddr[g]),
            .PWDATA  (pwdata[g]),
            .PSTRB   (pstrb[g]),
            .PRDATA  (prdata[g]),
            .PREADY  (pready[g]),
            .PSLVERR (pslverr[g]),
            .rf_wr_en(wr_en[g]),
            .rf_rd_en(rd_en[g]),
            .rf_addr (rf_addr[g]),
            .rf_wdata(rf_wdata[g]),
            .rf_wstrb(rf_wstrb[g]),
            .rf_rdata(rf_rdata[g])
        );
    end

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    function automatic int ws_of(input int g);
        return (g == 0) ? 0 : 3;
    endfunction

    function automatic int rl_of(input int g);
        return (g == 0) ? 1 : 5;
    endfunction

    // Register file behind each bridge; read data appears RD_LAT cycles
    // after the rf_rd_en cycle, random junk otherwise.
    logic [DW-1:0] rf_mem [2][8] = '{default: '0};
    logic [DW-1:0] pipe   [2][16];

    always @(posedge pclk) begin
        for (int g = 0; g < 2; g++) begin
            if (wr_en[g]) begin
                for (int b = 0; b < SW; b++) begin
                    if (rf_wstrb[g][b]) rf_mem[g][rf_addr[g]][8*b +: 8] <= rf_wdata[g][8*b +: 8];
                end
            end
            for (int i = 15; i > 0; i--) pipe[g][i] <= pipe[g][i-1];
            pipe[g][0] <= rd_en[g] ? rf_mem[g][rf_addr[g]] : $urandom();
        end
    end

    assign rf_rdata[0] = pipe[0][0];
    assign rf_rdata[1] = pipe[1][4];

    // Transaction-level reference state.
    int            total = 0;
    int            bad   = 0;
    logic          act   = 1'b0;
    int            cur_g = 0;
    int            phase = 0;
    int            e_n   = 0;
    logic          e_err, e_gwr, e_grd;
    logic [2:0]    e_idx;
    logic [DW-1:0] e_data;
    logic [SW-1:0] e_strb;
    logic [DW-1:0] prdata_mdl [2] = '{default: '0};
    logic [DW-1:0] mdl_mem    [2][8] = '{default: '0};

    task automatic chk(input int g, input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d got=%h exp=%h t=%0t", nm, g, got, exp, $time);
        end
    endtask

    // Cycle-by-cycle compare. Cycle 1 of a transfer is the setup cycle; the
    // rf strobe is expected in cycle 3 and PREADY in cycle 4+N.
    always @(negedge pclk) begin
        for (int g = 0; g < 2; g++) begin
            logic on, exp_rdy, exp_stb;
            on      = presetn && act && (cur_g == g);
            exp_rdy = on && (phase == 4 + e_n);
            exp_stb = on && (phase == 3);
            chk(g, "pready",  DW'(pready[g]),  DW'(exp_rdy));
            chk(g, "pslverr", DW'(pslverr[g]), DW'(exp_rdy && e_err));
            chk(g, "wr_en",   DW'(wr_en[g]),   DW'(exp_stb && e_gwr));
            chk(g, "rd_en",   DW'(rd_en[g]),   DW'(exp_stb && e_grd));
            chk(g, "prdata",  prdata[g],       prdata_mdl[g]);
            if (exp_stb && (e_gwr || e_grd)) begin
                chk(g, "rf_addr",  DW'(rf_addr[g]),  DW'(e_idx));
                chk(g, "rf_wstrb", DW'(rf_wstrb[g]), e_gwr ? DW'(e_strb) : '0);
                if (e_gwr) chk(g, "rf_wdata", rf_wdata[g], e_data);
            end
            if (!presetn) begin
                chk(g, "rst_rf_addr",  DW'(rf_addr[g]),  '0);
                chk(g, "rst_rf_wdata", rf_wdata[g],      '0);
                chk(g, "rst_rf_wstrb", DW'(rf_wstrb[g]), '0);
            end
        end
    end

    // One APB transfer. Entered and left just after a rising edge; the
    // following transfer may start immediately (back-to-back).
    task automatic xfer(input int g, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic [SW-1:0] strb,
                        input int abort_at,
                        output int cyc, output logic got_err, output logic [DW-1:0] got_rd);
        logic done;
        done    = 1'b0;
        cyc     = 0;
        got_err = 1'b0;
        got_rd  = '0;
        e_err   = (addr[1:0] != 2'b00) || ((addr >> 2) >= 5);
        e_idx   = addr[4:2];
        e_data  = data;
        e_strb  = strb;
        e_gwr   = wr && !e_err && (strb != '0);
        e_grd   = !wr && !e_err;
        e_n     = (wr || e_err) ? ws_of(g) : ((ws_of(g) > rl_of(g)) ? ws_of(g) : rl_of(g));
        cur_g   = g;
        phase   = 1;
        act     = 1'b1;
        psel[g]    = 1'b1;
        penable[g] = 1'b0;
        pwrite[g]  = wr;
        paddr[g]   = addr;
        pwdata[g]  = data;
        pstrb[g]   = strb;
        for (int k = 0; k < 40; k++) begin
            @(negedge pclk);
            if (pready[g]) begin
                done    = 1'b1;
                cyc     = phase;
                got_err = pslverr[g];
                got_rd  = prdata[g];
            end
            @(posedge pclk);
            #1;
            if (done) break;
            phase++;
            if (phase == 2) penable[g] = 1'b1;
            if (phase == abort_at) begin
                presetn    = 1'b0;
                act        = 1'b0;
                prdata_mdl = '{default: '0};
                psel[g]    = 1'b0;
                penable[g] = 1'b0;
                return;
            end
            if (phase == 4 + e_n) begin
                if (!wr) prdata_mdl[g] = e_err ? '0 : mdl_mem[g][e_idx];
                if (e_gwr) begin
                    for (int b = 0; b < SW; b++)
                        if (strb[b]) mdl_mem[g][e_idx][8*b +: 8] = data[8*b +: 8];
                end
            end
        end
        act        = 1'b0;
        psel[g]    = 1'b0;
        penable[g] = 1'b0;
        if (!done) chk(g, "timeout", '0, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    int            cyc;
    logic          er;
    logic [DW-1:0] rd;

    initial begin
        presetn = 1'b0;
        psel    = '{default: 1'b0};
        penable = '{default: 1'b0};
        pwrite  = '{default: 1'b0};
        paddr   = '{default: '0};
        pwdata  = '{default: '0};
        pstrb   = '{default: '0};
        idle(3);
        presetn = 1'b1;
        idle(1);

        // Directed transfers on the default instance
        xfer(0, 1'b1, 32'h08, 32'hA5A51234, 4'hF, 0, cyc, er, rd);
        chk(0, "t1_cycles", DW'(cyc), 32'd4);
        chk(0, "t1_err",    DW'(er),  32'd0);
        xfer(0, 1'b1, 32'h0C, 32'hDEADBEEF, 4'hF, 0, cyc, er, rd);
        xfer(0, 1'b0, 32'h0C, 32'h0, 4'h0, 0, cyc, er, rd);
        chk(0, "t2_prdata", rd, 32'hDEADBEEF);
        chk(0, "t2_cycles", DW'(cyc), 32'd5);
        xfer(0, 1'b1, 32'h14, 32'h12345678, 4'hF, 0, cyc, er, rd);
        chk(0, "t3_wr_err",    DW'(er),  32'd1);
        chk(0, "t3_wr_cycles", DW'(cyc), 32'd4);
        xfer(0, 1'b0, 32'h02, 32'h0, 4'h0, 0, cyc, er, rd);
        chk(0, "t3_rd_err",    DW'(er), 32'd1);
        chk(0, "t3_rd_prdata", rd,      32'd0);
        xfer(0, 1'b0, 32'h00, 32'h0, 4'h0, 0, cyc, er, rd);
        chk(0, "t3_ok_err", DW'(er), 32'd0);
        idle(2);
        xfer(0, 1'b1, 32'h00, 32'h11223344, 4'h3, 0, cyc, er, rd);
        xfer(0, 1'b0, 32'h00, 32'h0, 4'h0, 0, cyc, er, rd);
        chk(0, "t5_strb_rd", rd, 32'h00003344);
        xfer(0, 1'b1, 32'h04, 32'hFFFFFFFF, 4'h0, 0, cyc, er, rd);
        chk(0, "t5_zero_err",    DW'(er),  32'd0);
        chk(0, "t5_zero_cycles", DW'(cyc), 32'd4);
        xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 0, cyc, er, rd);
        chk(0, "t5_zero_rd", rd, 32'd0);
        xfer(0, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 0, cyc, er, rd);
        chk(0, "t5_b2b_wr_cycles", DW'(cyc), 32'd4);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, cyc, er, rd);
        chk(0, "t5_b2b_rd_cycles", DW'(cyc), 32'd5);
        chk(0, "t5_b2b_rd",        rd,       32'hCAFEF00D);
        idle(1);

        // Wait states and long read latency
        xfer(1, 1'b1, 32'h10, 32'h0000BEEF, 4'hF, 0, cyc, er, rd);
        chk(1, "t4_wr_cycles", DW'(cyc), 32'd7);
        xfer(1, 1'b1, 32'h04, 32'h5A5A0001, 4'hF, 0, cyc, er, rd);
        xfer(1, 1'b0, 32'h04, 32'h0, 4'h0, 0, cyc, er, rd);
        chk(1, "t4_rd_cycles", DW'(cyc), 32'd9);
        chk(1, "t4_rd",        rd,       32'h5A5A0001);
        idle(1);

        // Reset in the WAIT state of a read
        xfer(1, 1'b0, 32'h04, 32'h0, 4'h0, 5, cyc, er, rd);
        idle(2);
        presetn = 1'b1;
        xfer(0, 1'b0, 32'h00, 32'h0, 4'h0, 0, cyc, er, rd);
        chk(0, "t6_cycles", DW'(cyc), 32'd5);
        chk(0, "t6_rd",     rd,       32'h00003344);
        xfer(1, 1'b0, 32'h04, 32'h0, 4'h0, 0, cyc, er, rd);
        chk(1, "t6_rd1", rd, 32'h5A5A0001);

        // Randomized traffic on both instances
        for (int g = 0; g < 2; g++) begin
            for (int t = 0; t < 120; t++) begin
                int unsigned r;
                logic [AW-1:0] a;
                r = $urandom_range(0, 9);
                if (r < 7)       a = AW'($urandom_range(0, 7) * 4);
                else if (r == 7) a = AW'($urandom_range(0, 7) * 4 + $urandom_range(1, 3));
                else             a = AW'($urandom() | 32'h20) & ~AW'(3);
                xfer(g, 1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)), 0, cyc, er, rd);
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
            end
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
